// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and
// the helper that sizes the bit counter from the operand width.
package serial_subtractor_pkg;

  // Three-state sequencer: wait, shift one bit per cycle, present result.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // The counter must hold the values 0..width inclusive.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor used once per shift cycle by serial_subtractor.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow-out of a - b - bin.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B. Operands are rotated right one bit per SHIFT cycle,
// so after WIDTH rotations they are back in their original positions and
// the sign bits are still available for the overflow test. SHIFT spends
// WIDTH cycles producing bits plus one cycle moving the finished result
// into the output registers, so done appears WIDTH+1 cycles after start.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             bflop_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             ovf_q;

  logic             fs_d;
  logic             fs_bout;
  logic             ovf_d;

  full_subtractor u_fs (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (bflop_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // Signed overflow of the finished result, from the restored operand sign bits.
  always_comb begin
    ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_q[WIDTH-1] != a_q[WIDTH-1]);
  end

  // Sequencer, datapath shift registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      bflop_q  <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, FINISH: begin
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            res_q   <= '0;
            bflop_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          if (cnt_q == CNT_LAST) begin
            diff_q   <= res_q;
            borrow_q <= bflop_q;
            ovf_q    <= ovf_d;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= FINISH;
          end else begin
            a_q     <= {a_q[0], a_q[WIDTH-1:1]};
            b_q     <= {b_q[0], b_q[WIDTH-1:1]};
            res_q   <= {fs_d, res_q[WIDTH-1:1]};
            bflop_q <= fs_bout;
            cnt_q   <= cnt_q + CW'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign diff     = diff_q;
  assign borrow   = borrow_q;
  assign overflow = ovf_q;

endmodule
